// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, held-valid/ack handshake, framing and overrun flags
//   Optional 8E1 parity checking is enabled by defining UART_RX_PARITY_EN, which adds a PARITY state and the parity_err port.
//   Ports:
//     clk, rst_l  - system clock; synchronous active-low reset
//     rx          - asynchronous serial line, idle high
//     ack         - consumer pulse: byte taken, clears data_valid
//     rx_data     - last received byte, held until overwritten
//     data_valid  - high while rx_data is unconsumed
//     frame_err   - one-cycle pulse: stop bit sampled low
//     overrun     - one-cycle pulse: byte completed while data_valid=1 and ack=0
//     parity_err  - (UART_RX_PARITY_EN only) one-cycle pulse: even parity mismatch
//     busy        - high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst_l,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] rx_data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       overrun,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BRK
  } state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shreg_q, shreg_d, rx_data_q, rx_data_d;
  logic dv_q, dv_d, fe_q, fe_d, ov_q, ov_d;
  logic rs, half_tick, tick;
`ifdef UART_RX_PARITY_EN
  logic par_q, par_d, pe_q, pe_d;
`endif
  assign rs = sync_q[SYNC_STAGES-1];
  assign half_tick = cnt_q == HALF;
  assign tick = cnt_q == FULL;
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q   <= IDLE;
      sync_q    <= '1;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
      rx_data_q <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], rx};
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
      rx_data_q <= rx_data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    rx_data_d = rx_data_q;
    dv_d      = dv_q & ~ack;
    fe_d      = 1'b0;
    ov_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
    pe_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rs) state_d = START;
      end
      START: begin
        idx_d = '0;
        if (half_tick) state_d = rs ? IDLE : DATA;
      end
      DATA: if (tick) begin
        cnt_d   = '0;
        shreg_d = {rs, shreg_q[7:1]};
        idx_d   = idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (idx_q == 3'd7) state_d = PARITY;
`else
        if (idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        par_d   = rs;
        state_d = STOP;
      end
`endif
      STOP: if (tick) begin
`ifdef UART_RX_PARITY_EN
        pe_d = ^shreg_q ^ par_q;
`endif
        if (rs) begin
          rx_data_d = shreg_q;
          dv_d      = 1'b1;
          ov_d      = dv_q & ~ack;
          state_d   = IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = BRK;
        end
      end
      BRK: begin
        cnt_d = '0;
        if (rs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end
  assign rx_data    = rx_data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign overrun    = ov_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = pe_q;
`endif
  assign busy       = state_q != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0, rst_l = 1'b0, rx = 1'b1, ack = 1'b0;
  logic [7:0] rx_data;
  logic data_valid, frame_err, overrun, busy;
  int n_cmp = 0, n_err = 0, fe_cyc = 0, ov_cyc = 0;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
  int pe_cyc = 0;
`endif
  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .rst_l(rst_l),
    .rx(rx),
    .ack(ack),
    .rx_data(rx_data),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .overrun(overrun),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_l) begin
      fe_cyc = fe_cyc + int'(frame_err);
      ov_cyc = ov_cyc + int'(overrun);
`ifdef UART_RX_PARITY_EN
      pe_cyc = pe_cyc + int'(parity_err);
`endif
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic stopb, input logic parb, input logic ack_end);
    logic [10:0] bits;
    int nb;
`ifdef UART_RX_PARITY_EN
    bits = {stopb, parb, b, 1'b0};
    nb = 11;
`else
    bits = {parb, stopb, b, 1'b0};
    nb = 10;
`endif
    for (int i = 0; i < nb; i++) begin
      rx = bits[i];
      for (int j = 0; j < CPB; j++) begin
        ack = ack_end && (i == nb - 1) && (j == 10);
        tick(1);
      end
    end
    ack = 1'b0;
    rx = 1'b1;
  endtask
  task automatic do_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask
  initial begin
    tick(1);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      tick(1);
    end
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_valid", 32'(data_valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rx = 1'b1;
    rst_l = 1'b1;
    tick(10);
    chk("idle_busy", 32'(busy), 32'h0);
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    chk("a5_valid", 32'(data_valid), 32'h1);
    chk("a5_data", 32'(rx_data), 32'hA5);
    chk("a5_fe", 32'(fe_cyc), 32'h0);
    do_ack();
    chk("a5_ack_clear", 32'(data_valid), 32'h0);
    tick(5);
    rx = 1'b0;
    tick(4);
    chk("glitch_busy_hi", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(20);
    chk("glitch_busy_lo", 32'(busy), 32'h0);
    chk("glitch_valid", 32'(data_valid), 32'h0);
    chk("glitch_fe", 32'(fe_cyc), 32'h0);
`ifdef UART_RX_PARITY_EN
    send(8'h3C, 1'b0, 1'b0, 1'b0);
`else
    send(8'h3C, 1'b0, 1'b1, 1'b0);
`endif
    rx = 1'b0;
    tick(50);
    chk("brk_busy", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(10);
    chk("fe_once", 32'(fe_cyc), 32'h1);
    chk("fe_valid", 32'(data_valid), 32'h0);
    chk("fe_busy_lo", 32'(busy), 32'h0);
    send(8'h11, 1'b1, 1'b0, 1'b0);
    chk("x11_data", 32'(rx_data), 32'h11);
    chk("x11_valid", 32'(data_valid), 32'h1);
    do_ack();
    tick(3);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    send(8'hFE, 1'b1, 1'b1, 1'b0);
    chk("ovr_data", 32'(rx_data), 32'hFE);
    chk("ovr_pulse", 32'(ov_cyc), 32'h1);
    chk("ovr_valid", 32'(data_valid), 32'h1);
    do_ack();
    tick(3);
    send(8'h01, 1'b1, 1'b1, 1'b0);
    chk("b2b_first", 32'(rx_data), 32'h01);
    send(8'hFE, 1'b1, 1'b1, 1'b1);
    chk("ackedge_data", 32'(rx_data), 32'hFE);
    chk("ackedge_no_ovr", 32'(ov_cyc), 32'h1);
    chk("ackedge_valid", 32'(data_valid), 32'h1);
    do_ack();
    chk("final_fe", 32'(fe_cyc), 32'h1);
`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_ok_data", 32'(rx_data), 32'h07);
    chk("par_ok_pe", 32'(pe_cyc), 32'h0);
    do_ack();
    send(8'h07, 1'b1, 1'b0, 1'b0);
    chk("par_bad_pe", 32'(pe_cyc), 32'h1);
    chk("par_bad_data", 32'(rx_data), 32'h07);
    chk("par_bad_valid", 32'(data_valid), 32'h1);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
